// File: rtl/regfile_dump.sv
// regfile_dump: walks a register-file address range and streams each value out over valid/ready
module regfile_dump #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] first_addr,
    input  logic [ADDR_W-1:0] last_addr,
    input  logic              abort,
    output logic [ADDR_W-1:0] ra,
    input  logic [DATA_W-1:0] rd,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [ADDR_W-1:0] out_addr,
    output logic              out_last,
    output logic              busy,
    output logic              done
);
    typedef enum logic [1:0] {IDLE, READ, SEND} state_t;
    state_t state, state_n;
    logic [ADDR_W-1:0] cur, end_addr;
    // the read port is combinational, so ra simply tracks cur and holds it while idle
    assign ra = cur;
    assign busy = state != IDLE;
    // next-state selection; abort wins everywhere outside IDLE and blocks start inside it
    always_comb begin
        state_n = state;
        case (state)
            IDLE:    state_n = (start && !abort) ? READ : IDLE;
            READ:    state_n = abort ? IDLE : SEND;
            SEND:    state_n = abort ? IDLE : !out_ready ? SEND : out_last ? IDLE : READ;
            default: state_n = IDLE;
        endcase
    end
    // state register
    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else state <= state_n;
    end
    // range latch, snapshot capture and beat retirement
    always_ff @(posedge clk) begin
        if (reset) begin
            cur       <= '0;
            end_addr  <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_addr  <= '0;
            out_last  <= 1'b0;
            done      <= 1'b0;
        end else begin
            done <= 1'b0;
            if (state == IDLE && start && !abort) begin
                cur      <= first_addr;
                end_addr <= last_addr;
            end
            if (state == READ && !abort) begin
                out_data  <= rd;
                out_addr  <= cur;
                out_last  <= cur == end_addr;
                out_valid <= 1'b1;
            end
            if (state == SEND && (abort || out_ready)) out_valid <= 1'b0;
            if (state == SEND && !abort && out_ready) begin
                if (out_last) done <= 1'b1;
                else cur <= cur + 1'b1;
            end
        end
    end
endmodule
